fetch_queue_unit: RTL and testbench
===================================

// Module: fetch_queue_unit
// PURPOSE
//  Parametrised instruction-fetch stage. Generates sequential PCs, drives a fixed-latency-1
//  instruction memory, and buffers {pc,instr} pairs in a DEPTH-entry FIFO toward decode.
//  Decode stalls via a ready handshake. Branch redirects from decode flush the queue and
//  any in-flight fetch. Sits between the PC/imem and the IF/ID boundary.
// PARAMETERS
//  XLEN      32     PC/address width
//  ILEN      32     instruction width
//  DEPTH     4      fetch-queue entries; power of 2, >=2
//  RESET_PC  0      PC loaded on reset (XLEN bits)
//  PC_STEP   4      sequential PC increment
// PORTS
//  clk             in   1     single clock, all state on posedge
//  rst             in   1     synchronous reset, active-high
//  imem_en         out  1     fetch request this cycle; imem_addr valid
//  imem_addr       out  XLEN  fetch address (= fetch_pc)
//  imem_rdata      in   ILEN  instruction for the request issued on the previous cycle
//  redirect_valid  in   1     branch taken in decode; flush and refetch
//  redirect_pc     in   XLEN  target PC
//  id_ready        in   1     decode accepts head entry (low = hazard stall)
//  if_valid        out  1     queue head valid
//  if_pc           out  XLEN  head PC
//  if_instr        out  ILEN  head instruction
//  fetch_pc        out  XLEN  next PC to be requested
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, queue empty, inflight=0, imem_en=0, if_valid=0,
//    if_pc/if_instr=0.
//  - Issue: imem_en = !rst && !redirect_valid && (count+inflight < DEPTH); combinational.
//    On issue: fetch_pc <= fetch_pc+PC_STEP (mod 2^XLEN, wraps silently); inflight <= 1,
//    tag_pc <= fetch_pc.
//  - Response: the cycle after issue, imem_rdata is written with tag_pc into tail;
//    count+1. Latency from issue to if_valid: 1 cycle (queue empty).
//  - Pop: if_valid && id_ready -> head advances; count-1. Head is held stable while
//    id_ready=0.
//  - Push and pop in the same cycle: count unchanged. Credit rule guarantees no overflow.
//  - Redirect (highest priority): queue cleared, in-flight response discarded
//    (inflight <= 0), fetch_pc <= redirect_pc. No issue that cycle. First fetch of the
//    target is the next cycle. The target enters if_valid 2 cycles after redirect.
//  - Redirect with a simultaneous pop: the pop is ignored. Decode must treat the redirect
//    cycle as consuming nothing.
//  - Full (count==DEPTH): no issue. fetch_pc holds.
//  - Empty: if_valid=0. if_pc/if_instr are don't-care.
//  - rst mid-operation overrides everything, including redirect. Queue and inflight are
//    dropped.
//  - Pointers are log2(DEPTH) bits and wrap. count is log2(DEPTH)+1 bits.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds 32-bit outputs perf_fetch_cnt (issues), perf_flush_cnt
//    (redirect cycles), perf_stall_cnt (if_valid && !id_ready cycles). All are zero on
//    rst and saturate at 2^32-1.
//  FETCH_PERF_EN undefined: no counters and no such ports. Functional behaviour is
//    identical.
// TESTING
//  1. rst high 2 cycles, then low, id_ready=1 -> imem_addr 0,4,8,... on consecutive
//     cycles; if_pc=0 one cycle after first issue; one instruction per cycle thereafter.
//  2. DEPTH=4, id_ready=0 -> exactly 4 issues (0..12), then imem_en=0, fetch_pc=16;
//     if_pc held at 0.
//  3. Queue holds 0..8, redirect_valid pulse with redirect_pc=0x100 -> if_valid=0 next
//     cycle; imem_addr=0x100 next cycle; if_pc=0x100 two cycles after the pulse;
//     in-flight 0xC is never presented.
//  4. Redirect and id_ready=1 in the same cycle -> head not consumed; queue empty after.
//  5. RESET_PC=0xFFFFFFF8, XLEN=32 -> fetch order FFFFFFF8, FFFFFFFC, 0, 4.
//  6. rst asserted with 3 entries queued and one in flight -> next cycle if_valid=0,
//     fetch_pc=RESET_PC; perf counters=0 if FETCH_PERF_EN.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: sequential PC generator, latency-1 imem driver and DEPTH-entry
// {pc,instr} queue toward decode. Optional perf counters when FETCH_PERF_EN is defined.
module fetch_queue_unit #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [ILEN-1:0] if_instr,
`ifdef FETCH_PERF_EN
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_flush_cnt,
    output logic [31:0]     perf_stall_cnt,
`endif
    output logic [XLEN-1:0] fetch_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] fetch_pc_reg;
    logic [XLEN-1:0] tag_pc_reg;
    logic            inflight_reg;
    logic [CW-1:0]   count_reg;
    logic [PW-1:0]   head_reg;
    logic [PW-1:0]   tail_reg;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [ILEN-1:0] instr_mem [DEPTH];

    logic [CW:0] used;
    logic        issue;
    logic        queue_empty;
    logic        bypass_pop;
    logic        push;
    logic        pop;

    // Credits count both stored entries and the outstanding response, so the queue never overflows.
    assign used        = {1'b0, count_reg} + (CW+1)'(inflight_reg);
    assign issue       = !rst && !redirect_valid && (used < (CW+1)'(DEPTH));
    assign queue_empty = (count_reg == '0);
    // An arriving response is presented straight away when the queue is empty.
    assign bypass_pop  = queue_empty && inflight_reg && id_ready;
    assign push        = inflight_reg && !bypass_pop;
    assign pop         = !queue_empty && id_ready;

    assign imem_en   = issue;
    assign imem_addr = fetch_pc_reg;
    assign fetch_pc  = fetch_pc_reg;
    assign if_valid  = !queue_empty || inflight_reg;

    always_comb begin
        if_pc    = '0;
        if_instr = '0;
        if (!queue_empty) begin
            if_pc    = pc_mem[head_reg];
            if_instr = instr_mem[head_reg];
        end else if (inflight_reg) begin
            if_pc    = tag_pc_reg;
            if_instr = imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg <= RESET_PC;
            tag_pc_reg   <= '0;
            inflight_reg <= 1'b0;
            count_reg    <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
        end else if (redirect_valid) begin
            fetch_pc_reg <= redirect_pc;
            inflight_reg <= 1'b0;
            count_reg    <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
        end else begin
            if (issue) begin
                fetch_pc_reg <= fetch_pc_reg + XLEN'(PC_STEP);
                tag_pc_reg   <= fetch_pc_reg;
            end
            inflight_reg <= issue;
            if (push) tail_reg <= tail_reg + 1'b1;
            if (pop)  head_reg <= head_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid && push) begin
            pc_mem[tail_reg]    <= tag_pc_reg;
            instr_mem[tail_reg] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    logic [2:0] perf_ev;
    assign perf_ev = {if_valid && !id_ready, redirect_valid, issue};

    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
        logic [31:0] cnt_reg;
        always_ff @(posedge clk) begin
            if (rst)
                cnt_reg <= '0;
            else if (perf_ev[gi] && (cnt_reg != '1))
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign perf_fetch_cnt = g_perf[0].cnt_reg;
    assign perf_flush_cnt = g_perf[1].cnt_reg;
    assign perf_stall_cnt = g_perf[2].cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: stimulus queues expected pops and signal checks,
// a negedge monitor does every comparison.
module tb_fetch_queue_unit;
    localparam int K_EN = 0, K_ADDR = 1, K_VALID = 2, K_PC = 3, K_INSTR = 4,
                   K_FPC = 5, K_WADDR = 6, K_WEN = 7, K_PERF = 8;

    typedef struct {
        int          kind;
        logic [31:0] exp;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] fetch_pc;

    logic        rst_w = 1'b1;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_pc = '0;
    logic        w_ready = 1'b1;
    logic [31:0] w_rdata = '0;
    logic        w_en;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_pc;
    logic [31:0] w_instr;
    logic [31:0] w_fpc;
`ifdef FETCH_PERF_EN
    logic [31:0] pf_fetch, pf_flush, pf_stall;
    logic [31:0] wpf_fetch, wpf_flush, wpf_stall;
`endif

    chk_t        chk_q[$];
    logic [31:0] sb[$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    fetch_queue_unit dut (
        .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
`ifdef FETCH_PERF_EN
        .perf_fetch_cnt(pf_fetch), .perf_flush_cnt(pf_flush), .perf_stall_cnt(pf_stall),
`endif
        .fetch_pc(fetch_pc)
    );

    fetch_queue_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst(rst_w), .imem_en(w_en), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
        .id_ready(w_ready), .if_valid(w_valid), .if_pc(w_pc), .if_instr(w_instr),
`ifdef FETCH_PERF_EN
        .perf_fetch_cnt(wpf_fetch), .perf_flush_cnt(wpf_flush), .perf_stall_cnt(wpf_stall),
`endif
        .fetch_pc(w_fpc)
    );

    function automatic logic [31:0] instr_of(logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Fixed latency-1 instruction memory.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= instr_of(imem_addr);
    end

    function automatic string name_of(int k);
        case (k)
            K_EN:    return "imem_en";
            K_ADDR:  return "imem_addr";
            K_VALID: return "if_valid";
            K_PC:    return "if_pc";
            K_INSTR: return "if_instr";
            K_FPC:   return "fetch_pc";
            K_WADDR: return "wrap_imem_addr";
            K_WEN:   return "wrap_imem_en";
            default: return "perf_cnt";
        endcase
    endfunction

    always @(negedge clk) begin
        chk_t        c;
        logic [31:0] act;
        logic [31:0] e;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            case (c.kind)
                K_EN:    act = {31'b0, imem_en};
                K_ADDR:  act = imem_addr;
                K_VALID: act = {31'b0, if_valid};
                K_PC:    act = if_pc;
                K_INSTR: act = if_instr;
                K_FPC:   act = fetch_pc;
                K_WADDR: act = w_addr;
                K_WEN:   act = {31'b0, w_en};
`ifdef FETCH_PERF_EN
                default: act = pf_fetch | pf_flush | pf_stall;
`else
                default: act = '0;
`endif
            endcase
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s: got %h want %h at %0t", name_of(c.kind), act, c.exp, $time);
            end
        end
        if (!rst && !redirect_valid && if_valid && id_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pop: got pc %h want none", if_pc);
            end else begin
                e = sb.pop_front();
                if (if_pc !== e || if_instr !== instr_of(e)) begin
                    errors++;
                    $display("FAIL pop: got pc %h instr %h want pc %h instr %h",
                             if_pc, if_instr, e, instr_of(e));
                end else begin
                    $display("pop pc=%h instr=%h ok", if_pc, if_instr);
                end
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(int k, logic [31:0] v);
        chk_q.push_back('{k, v});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        id_ready = 1'b0;
        redirect_valid = 1'b0;
        sb.delete();
        step(2);
    endtask

    task automatic expect_seq(logic [31:0] base, int n);
        for (int i = 0; i < n; i++) sb.push_back(base + 32'(4 * i));
    endtask

    initial begin
        // Reset state and sequential fetch with decode always ready.
        step(2);
        chk(K_EN, 0); chk(K_VALID, 0); chk(K_PC, 0); chk(K_INSTR, 0); chk(K_FPC, 0);
`ifdef FETCH_PERF_EN
        chk(K_PERF, 0);
`endif
        step(1);
        rst = 1'b0; id_ready = 1'b1;
        expect_seq(32'h0, 16);
        chk(K_EN, 1); chk(K_ADDR, 32'h0); chk(K_VALID, 0);
        step(1);
        chk(K_ADDR, 32'h4); chk(K_VALID, 1); chk(K_PC, 32'h0); chk(K_INSTR, 32'h0000_FFFF);
        step(1);
        chk(K_ADDR, 32'h8); chk(K_FPC, 32'h8); chk(K_PC, 32'h4);
        step(1);
        chk(K_PC, 32'h8); chk(K_INSTR, 32'h0008_FFF7);
        step(1);

        // Decode stalled: exactly DEPTH issues, then hold.
        do_reset();
        rst = 1'b0;
        expect_seq(32'h0, 16);
        chk(K_EN, 1); chk(K_ADDR, 32'h0);
        step(1); chk(K_ADDR, 32'h4); chk(K_PC, 32'h0);
        step(1); chk(K_ADDR, 32'h8);
        step(1); chk(K_ADDR, 32'hC);
        step(1); chk(K_EN, 0); chk(K_FPC, 32'h10); chk(K_PC, 32'h0);
        step(1); chk(K_EN, 0); chk(K_FPC, 32'h10); chk(K_VALID, 1); chk(K_PC, 32'h0);
        id_ready = 1'b1;
        step(1); id_ready = 1'b0;
        chk(K_EN, 1); chk(K_ADDR, 32'h10); chk(K_PC, 32'h4);
        step(1); chk(K_EN, 0); chk(K_FPC, 32'h14);
        step(1);

        // Redirect with 0..8 queued, 0xC in flight, and a simultaneous ready.
        do_reset();
        rst = 1'b0;
        step(4);
        chk(K_EN, 0); chk(K_PC, 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h100; id_ready = 1'b1;
        sb.delete();
        expect_seq(32'h100, 16);
        step(1);
        redirect_valid = 1'b0; id_ready = 1'b0;
        chk(K_VALID, 0); chk(K_EN, 1); chk(K_ADDR, 32'h100);
        step(1);
        chk(K_VALID, 1); chk(K_PC, 32'h100); chk(K_INSTR, 32'h0100_FEFF); chk(K_ADDR, 32'h104);
        id_ready = 1'b1;
        step(1); chk(K_PC, 32'h104);
        step(1);

        // Reset with 3 queued and 1 in flight overrides a simultaneous redirect.
        do_reset();
        rst = 1'b0;
        step(4);
        chk(K_VALID, 1); chk(K_EN, 0);
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        sb.delete();
        step(1);
        redirect_valid = 1'b0;
        chk(K_VALID, 0); chk(K_FPC, 32'h0); chk(K_EN, 0); chk(K_PC, 32'h0);
`ifdef FETCH_PERF_EN
        chk(K_PERF, 0);
`endif
        step(1);
        rst = 1'b0;
        chk(K_EN, 1); chk(K_ADDR, 32'h0);
        step(1);
        rst = 1'b1;

        // PC wrap on the second instance.
        step(1);
        chk(K_WEN, 0); chk(K_WADDR, 32'hFFFF_FFF8);
        step(1);
        rst_w = 1'b0;
        chk(K_WEN, 1); chk(K_WADDR, 32'hFFFF_FFF8);
        step(1); chk(K_WADDR, 32'hFFFF_FFFC);
        step(1); chk(K_WADDR, 32'h0000_0000);
        step(1); chk(K_WADDR, 32'h0000_0004);
        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
